rgb_align_packer: RTL and testbench
===================================

Name: rgb_align_packer

Overview:
Parametrised successor to the 3-channel interpolation output merger. It takes NUM_CH independent per-channel pixel streams, each with its own vsync/href/data from an interpolation lane. Per-channel skew FIFOs realign the streams, so output timing no longer depends on channel 0. Aligned pixels are packed into one OUT_W word, and frame-level skew and overflow faults are detected and reported. It sits between the per-channel bilinear lanes and the frame-buffer writer.

Parameters:
NUM_CH, 3, number of channel lanes (1..4)
CH_W, 8, bits per channel sample
OUT_W, 32, packed output width; must be >= NUM_CH*CH_W (elaboration error otherwise)
FIFO_DEPTH, 8, entries per skew FIFO; power of 2, >= 4
SKEW_MAX, 64, max cycles between first and last channel vsync rise
ALPHA_VAL, 8'hFF, pad byte value (used only with the optional feature)

Ports:
clk_in1  in  1  single processing clock
rst_n  in  1  asynchronous active-low reset
ch_vsync  in  NUM_CH  per-channel frame valid, bit i = channel i
ch_href  in  NUM_CH  per-channel pixel valid
ch_data  in  NUM_CH*CH_W  channel i at [i*CH_W +: CH_W]
swap_order  in  1  0: channel 0 most significant; 1: reversed order
clr_err  in  1  one-cycle pulse, clears sticky errors
post_img_vsync  out  1  aligned frame valid
post_img_href  out  1  packed pixel valid
post_img_data  out  OUT_W  packed pixel
align_err  out  1  sticky skew/length mismatch flag
ovf_err  out  1  sticky FIFO overflow flag
frame_pix_cnt  out  24  pixels emitted in the last completed frame

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM IDLE, FIFOs empty, counters 0.
- FSM states and transitions:
  - IDLE: on a rising edge of any ch_vsync bit, go to SYNC and set skew_cnt=0.
  - SYNC: skew_cnt increments each cycle.
    - When all ch_vsync bits are 1: flush all FIFOs, go to ACTIVE, post_img_vsync<=1, pixel counter=0.
    - If skew_cnt reaches SKEW_MAX-1 first: align_err<=1, go to DROP.
  - ACTIVE: push and pop enabled. When all ch_vsync bits are 0, go to DRAIN.
  - DRAIN: pops continue while all FIFOs are non-empty. Once any FIFO is empty:
    - if any other FIFO is non-empty, set align_err;
    - flush all FIFOs, post_img_vsync<=0, frame_pix_cnt<=pixel counter;
    - go to IDLE.
  - DROP: href ignored, post_img_vsync stays 0. When all ch_vsync bits are 0, go to IDLE.
- Push: in ACTIVE, ch_href[i]=1 writes ch_data slice i into FIFO i.
  - Write to a full FIFO: the sample is dropped and ovf_err<=1.
  - Push in DRAIN: the sample is written.
- Pop: when all FIFOs are non-empty in ACTIVE/DRAIN, pop all FIFOs in the same cycle. Push and pop may happen in the same cycle on a full FIFO; the pop frees the slot, so no overflow.
- Latency: 2 cycles, from the clock edge sampling the last-arriving channel sample to post_img_href=1 with data.
- post_img_href pulses for one cycle per popped set. Data holds its last value when href=0.
- Packing, with packed = concatenation of channels:
  - swap_order=0: packed = {ch0,ch1,...,chN-1}.
  - swap_order=1: packed = {chN-1,...,ch0}.
  - packed is right-aligned in OUT_W; upper pad bits are 0.
- swap_order is sampled only on entry to ACTIVE; mid-frame changes take effect next frame.
- The pixel counter increments per emitted pixel and saturates at 24'hFFFFFF.
- Sticky errors: clr_err clears them. If clr_err coincides with a new error event, the flag stays set (set wins).
- Reset mid-frame: immediate return to reset state; the next frame starts only at a fresh vsync rise.

Optional Feature:
ALIGN_PACK_ALPHA_EN.
- Defined: the CH_W bits directly above the packed channels are filled with ALPHA_VAL when OUT_W >= (NUM_CH+1)*CH_W. With defaults, output = {8'hFF,R,G,B}. Remaining pad bits are 0.
- Undefined: all pad bits are 0. With defaults, output = {8'h00,R,G,B}.

Test Plan:
- All channels aligned, 4x2 frame, R=8'h10+n, G=8'h20+n, B=8'h30+n -> 8 href pulses with data 32'h00102030..; frame_pix_cnt=8; latency 2 cycles.
- Channel 2 delayed 5 cycles (vsync and href) -> identical packed output to the aligned case; align_err=0; first href 2 cycles after channel 2's first sample.
- Channel 1 vsync rises SKEW_MAX cycles after channel 0 -> align_err=1; no post_img_vsync/href for that frame; next aligned frame outputs normally.
- Channel 0 href held off for FIFO_DEPTH+1 samples while channels 1/2 run -> ovf_err=1. clr_err pulse -> ovf_err=0.
- swap_order=1 with R=8'hAA, G=8'hBB, B=8'hCC -> 32'h00CCBBAA; toggling swap_order mid-frame leaves the current frame unchanged.
- Channel 1 emits one extra pixel in a frame -> align_err=1 at DRAIN; FIFOs empty afterwards; following frame is clean.

Source files
------------

// File: rtl/rgb_align_packer.sv
// rgb_align_packer
// Realigns NUM_CH independent channel streams (vsync/href/data per lane)
// through per-channel skew FIFOs, packs each aligned set of samples into
// one OUT_W word and reports frame-level skew/length and overflow faults.
//
// Optional feature macro: ALIGN_PACK_ALPHA_EN
//   defined   -> the CH_W bits directly above the packed channels carry
//                ALPHA_VAL (when OUT_W leaves room for them)
//   undefined -> every pad bit above the packed channels is 0
module rgb_align_packer #(
  parameter int              NUM_CH     = 3,
  parameter int              CH_W       = 8,
  parameter int              OUT_W      = 32,
  parameter int              FIFO_DEPTH = 8,
  parameter int              SKEW_MAX   = 64,
  parameter logic [CH_W-1:0] ALPHA_VAL  = 8'hFF
) (
  input  logic                   clk_in1,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      ch_vsync,
  input  logic [NUM_CH-1:0]      ch_href,
  input  logic [NUM_CH*CH_W-1:0] ch_data,
  input  logic                   swap_order,
  input  logic                   clr_err,
  output logic                   post_img_vsync,
  output logic                   post_img_href,
  output logic [OUT_W-1:0]       post_img_data,
  output logic                   align_err,
  output logic                   ovf_err,
  output logic [23:0]            frame_pix_cnt
);

  localparam int PACK_W = NUM_CH * CH_W;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SKW    = (SKEW_MAX > 1) ? $clog2(SKEW_MAX) : 1;

  localparam logic [AW:0]    FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [SKW-1:0] SKEW_LAST = SKW'(SKEW_MAX - 1);
  localparam logic [23:0]    PIX_MAX   = 24'hFFFFFF;

`ifdef ALIGN_PACK_ALPHA_EN
  localparam bit ALPHA_ON = 1'b1;
`else
  localparam bit ALPHA_ON = 1'b0;
`endif

  // Constant pad word OR-ed over the packed channels; zero unless the
  // alpha feature is built in and there is room for a whole alpha lane.
  localparam logic [OUT_W-1:0] ALPHA_WORD =
    (ALPHA_ON && (OUT_W >= PACK_W + CH_W)) ? (OUT_W'(ALPHA_VAL) << PACK_W) : '0;

  // Reject illegal configurations at elaboration time.
  generate
    if (OUT_W < NUM_CH * CH_W) begin : g_chk_out_w
      $error("rgb_align_packer: OUT_W must be >= NUM_CH*CH_W");
    end
    if ((NUM_CH < 1) || (NUM_CH > 4)) begin : g_chk_num_ch
      $error("rgb_align_packer: NUM_CH must be 1..4");
    end
    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
      $error("rgb_align_packer: FIFO_DEPTH must be a power of 2 and >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_ACTIVE = 3'd2,
    S_DRAIN  = 3'd3,
    S_DROP   = 3'd4
  } state_t;

  state_t              r_state;
  logic [SKW-1:0]      r_skew_cnt;
  logic [NUM_CH-1:0]   r_vsync_d;
  logic                r_swap;
  logic                r_pop_d;
  logic [23:0]         r_pix_cnt;

  logic                w_all_on;
  logic                w_all_off;
  logic                w_rise;
  logic                w_timeout;
  logic                w_sync_done;
  logic                w_drain_done;
  logic                w_flush;
  logic                w_push_en;
  logic                w_pop;
  logic                w_align_ev;
  logic                w_ovf_ev;
  logic [NUM_CH-1:0]   w_empty;
  logic [NUM_CH-1:0]   w_ovf_vec;
  logic [CH_W-1:0]     w_rd_data [NUM_CH];
  logic [PACK_W-1:0]   w_ch_packed;
  logic [OUT_W-1:0]    w_packed;

  // Frame control decode shared by the FSM and the skew FIFOs.
  always_comb begin
    w_all_on     = &ch_vsync;
    w_all_off    = ~|ch_vsync;
    w_rise       = |(ch_vsync & ~r_vsync_d);
    // The skew window closing takes priority over a late all-on.
    w_timeout    = (r_state == S_SYNC) && (r_skew_cnt == SKEW_LAST);
    w_sync_done  = (r_state == S_SYNC) && !w_timeout && w_all_on;
    w_push_en    = (r_state == S_ACTIVE) || (r_state == S_DRAIN);
    w_pop        = w_push_en && (w_empty == '0);
    // Leave DRAIN only once a lane has run dry and the last popped set has
    // been emitted, so the final href still falls inside post_img_vsync.
    w_drain_done = (r_state == S_DRAIN) && (w_empty != '0) && !r_pop_d;
    w_flush      = w_sync_done || w_drain_done;
    w_align_ev   = w_timeout || (w_drain_done && (~w_empty != '0));
    w_ovf_ev     = |w_ovf_vec;
  end

  // One skew FIFO per channel: RAM array with a registered read port.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fifo
      logic [CH_W-1:0] r_mem [FIFO_DEPTH];
      logic [CH_W-1:0] r_rd_data;
      logic [AW-1:0]   r_wr_ptr;
      logic [AW-1:0]   r_rd_ptr;
      logic [AW:0]     r_cnt;
      logic            w_push;
      logic            w_full;
      logic            w_wr;

      assign w_push = w_push_en && ch_href[gi];
      assign w_full = (r_cnt == FULL_CNT);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      assign w_wr   = w_push && (!w_full || w_pop);
      assign w_ovf_vec[gi] = w_push && w_full && !w_pop;
      assign w_empty[gi]   = (r_cnt == '0);
      assign w_rd_data[gi] = r_rd_data;

      // Storage and registered read; no reset so it maps onto block RAM.
      always_ff @(posedge clk_in1) begin
        if (w_wr) begin
          r_mem[r_wr_ptr] <= ch_data[gi*CH_W +: CH_W];
        end
        if (w_pop) begin
          r_rd_data <= r_mem[r_rd_ptr];
        end
      end

      // Pointer and occupancy bookkeeping; a flush empties the lane.
      always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_cnt    <= '0;
        end else if (w_flush) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_cnt    <= '0;
        end else begin
          if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
          case ({w_wr, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
          endcase
        end
      end
    end
  endgenerate

  // Channel packing: channel 0 lands in the top lane unless the frame
  // latched swap_order, in which case channel 0 is the bottom lane.
  always_comb begin
    w_ch_packed = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_swap) begin
        w_ch_packed[i*CH_W +: CH_W] = w_rd_data[i];
      end else begin
        w_ch_packed[(NUM_CH-1-i)*CH_W +: CH_W] = w_rd_data[i];
      end
    end
  end

  assign w_packed = OUT_W'(w_ch_packed) | ALPHA_WORD;

  // Frame FSM with registered outputs, pixel counting and sticky errors.
  always_ff @(posedge clk_in1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_skew_cnt     <= '0;
      // All-ones so a vsync still high when reset lifts is not seen as a rise.
      r_vsync_d      <= '1;
      r_swap         <= 1'b0;
      r_pop_d        <= 1'b0;
      r_pix_cnt      <= '0;
      post_img_vsync <= 1'b0;
      post_img_href  <= 1'b0;
      post_img_data  <= '0;
      align_err      <= 1'b0;
      ovf_err        <= 1'b0;
      frame_pix_cnt  <= '0;
    end else begin
      r_vsync_d     <= ch_vsync;
      r_pop_d       <= w_pop;
      post_img_href <= r_pop_d;
      if (r_pop_d) begin
        post_img_data <= w_packed;
      end

      // Count at pop time so the total is final when DRAIN closes the frame.
      if (w_sync_done) begin
        r_pix_cnt <= '0;
      end else if (w_pop && (r_pix_cnt != PIX_MAX)) begin
        r_pix_cnt <= r_pix_cnt + 24'd1;
      end

      // Sticky flags: a new event in the same cycle beats clr_err.
      if (w_align_ev) begin
        align_err <= 1'b1;
      end else if (clr_err) begin
        align_err <= 1'b0;
      end
      if (w_ovf_ev) begin
        ovf_err <= 1'b1;
      end else if (clr_err) begin
        ovf_err <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state    <= S_SYNC;
            r_skew_cnt <= '0;
          end
        end
        S_SYNC: begin
          if (w_timeout) begin
            r_state <= S_DROP;
          end else if (w_all_on) begin
            r_state        <= S_ACTIVE;
            post_img_vsync <= 1'b1;
            r_swap         <= swap_order;
          end else begin
            r_skew_cnt <= r_skew_cnt + 1'b1;
          end
        end
        S_ACTIVE: begin
          if (w_all_off) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_drain_done) begin
            r_state        <= S_IDLE;
            post_img_vsync <= 1'b0;
            frame_pix_cnt  <= r_pix_cnt;
          end
        end
        S_DROP: begin
          if (w_all_off) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_align_packer.sv
// Directed bench for rgb_align_packer (default parameters, 3 channels).
// A frame scheduler drives per-channel vsync/href/data and, from the
// schedule alone, predicts each packed pixel and the cycle it must appear.
module tb_rgb_align_packer;

  localparam int TAIL = 2;

`ifdef ALIGN_PACK_ALPHA_EN
  localparam logic [7:0] PAD = 8'hFF;
`else
  localparam logic [7:0] PAD = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ch_vsync;
  logic [2:0]  ch_href;
  logic [23:0] ch_data;
  logic        swap_order;
  logic        clr_err;
  logic        post_img_vsync;
  logic        post_img_href;
  logic [31:0] post_img_data;
  logic        align_err;
  logic        ovf_err;
  logic [23:0] frame_pix_cnt;

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  bit          ignore_out = 1'b0;
  bit          first_seen;
  logic [31:0] first_data;
  logic [31:0] last_data;
  int          first_href_cyc;
  int          first_done_cyc;
  int          href_cnt;
  int          vs_cycles;

  rgb_align_packer dut (
    .clk_in1        (clk),
    .rst_n          (rst_n),
    .ch_vsync       (ch_vsync),
    .ch_href        (ch_href),
    .ch_data        (ch_data),
    .swap_order     (swap_order),
    .clr_err        (clr_err),
    .post_img_vsync (post_img_vsync),
    .post_img_href  (post_img_href),
    .post_img_data  (post_img_data),
    .align_err      (align_err),
    .ovf_err        (ovf_err),
    .frame_pix_cnt  (frame_pix_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] pack3(input bit sw, input logic [7:0] c0, c1, c2);
    return sw ? {PAD, c2, c1, c0} : {PAD, c0, c1, c2};
  endfunction

  // Output monitor: every href must match the next predicted pixel.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (post_img_vsync) vs_cycles++;
        if (post_img_href) begin
          href_cnt++;
          if (!first_seen) begin
            first_seen     = 1'b1;
            first_data     = post_img_data;
            first_href_cyc = cyc;
          end
          last_data = post_img_data;
          if (!ignore_out) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_href", 64'(post_img_href), 64'(0));
            end else begin
              e = exp_q.pop_front();
              chk("href_cycle", 64'(cyc), 64'(e.cyc));
              chk("href_data", 64'(post_img_data), 64'(e.data));
            end
            chk("href_inside_vsync", 64'(post_img_vsync), 64'(1));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ch_vsync = '0;
      ch_href  = '0;
      ch_data  = '0;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // Drive one frame. Channel c raises vsync at d[c], sends its samples from
  // d[c]+lead (+hold0 on channel 0), channel 1 may send extra samples.
  task automatic run_frame(input int d0, d1, d2, input int lead, input int hold0,
                           input int extra1, input int npix,
                           input logic [7:0] b0, b1, b2,
                           input bit expect_out, input bit toggle_swap);
    int d[3];
    int hs[3];
    int n[3];
    int vo[3];
    logic [7:0] base[3];
    int t_end;
    int arr;
    bit fswap;
    d    = '{d0, d1, d2};
    base = '{b0, b1, b2};
    t_end = 0;
    for (int c = 0; c < 3; c++) begin
      hs[c] = d[c] + lead + ((c == 0) ? hold0 : 0);
      n[c]  = npix + ((c == 1) ? extra1 : 0);
      vo[c] = hs[c] + n[c] + TAIL;
      if (vo[c] > t_end) t_end = vo[c];
    end
    fswap          = swap_order;
    first_seen     = 1'b0;
    href_cnt       = 0;
    vs_cycles      = 0;
    first_done_cyc = -1;
    for (int t = 0; t <= t_end; t++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        ch_vsync[c] = (t >= d[c]) && (t < vo[c]);
        ch_href[c]  = (t >= hs[c]) && (t < hs[c] + n[c]);
        ch_data[c*8 +: 8] = ch_href[c] ? 8'(base[c] + 8'(t - hs[c])) : 8'h00;
      end
      if (toggle_swap && (t == hs[0] + 3)) swap_order = ~swap_order;
      for (int k = 0; k < npix; k++) begin
        arr = hs[0] + k;
        if (hs[1] + k > arr) arr = hs[1] + k;
        if (hs[2] + k > arr) arr = hs[2] + k;
        if (t == arr) begin
          if (first_done_cyc < 0) first_done_cyc = cyc;
          if (expect_out)
            exp_q.push_back('{cyc + 3, pack3(fswap, 8'(base[0] + 8'(k)),
                                             8'(base[1] + 8'(k)), 8'(base[2] + 8'(k)))});
        end
      end
    end
    idle(12);
    if (expect_out) chk("expected_pixels_all_emitted", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    rst_n      = 1'b0;
    ch_vsync   = '0;
    ch_href    = '0;
    ch_data    = '0;
    swap_order = 1'b0;
    clr_err    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vsync", 64'(post_img_vsync), 64'(0));
    chk("rst_href", 64'(post_img_href), 64'(0));
    chk("rst_data", 64'(post_img_data), 64'(0));
    chk("rst_align", 64'(align_err), 64'(0));
    chk("rst_ovf", 64'(ovf_err), 64'(0));
    chk("rst_fpc", 64'(frame_pix_cnt), 64'(0));
    rst_n = 1'b1;
    idle(3);

    // Aligned 4x2 frame.
    run_frame(0, 0, 0, 8, 0, 0, 8, 8'h10, 8'h20, 8'h30, 1'b1, 1'b0);
    chk("t1_fpc", 64'(frame_pix_cnt), 64'(8));
    chk("t1_align", 64'(align_err), 64'(0));
    chk("t1_ovf", 64'(ovf_err), 64'(0));
    chk("t1_href_count", 64'(href_cnt), 64'(8));
    chk("t1_first_data", 64'(first_data), 64'({PAD, 24'h102030}));
    chk("t1_last_data", 64'(last_data), 64'({PAD, 24'h172737}));
    chk("t1_latency", 64'(first_href_cyc - first_done_cyc), 64'(3));

    // Channel 2 lags by 5 cycles on vsync and href.
    run_frame(0, 0, 5, 8, 0, 0, 8, 8'h10, 8'h20, 8'h30, 1'b1, 1'b0);
    chk("t2_fpc", 64'(frame_pix_cnt), 64'(8));
    chk("t2_align", 64'(align_err), 64'(0));
    chk("t2_first_data", 64'(first_data), 64'({PAD, 24'h102030}));
    chk("t2_latency", 64'(first_href_cyc - first_done_cyc), 64'(3));

    // Channel 1 vsync rises SKEW_MAX cycles late: frame dropped.
    run_frame(0, 64, 0, 70, 0, 0, 8, 8'h40, 8'h50, 8'h60, 1'b0, 1'b0);
    chk("t3_align", 64'(align_err), 64'(1));
    chk("t3_no_vsync", 64'(vs_cycles), 64'(0));
    chk("t3_no_href", 64'(href_cnt), 64'(0));
    pulse_clr();
    chk("t3_align_cleared", 64'(align_err), 64'(0));
    run_frame(0, 0, 0, 8, 0, 0, 8, 8'h01, 8'h02, 8'h03, 1'b1, 1'b0);
    chk("t3_next_fpc", 64'(frame_pix_cnt), 64'(8));
    chk("t3_next_align", 64'(align_err), 64'(0));

    // Channel 0 held off while channels 1/2 overrun their FIFOs.
    ignore_out = 1'b1;
    run_frame(0, 0, 0, 8, 10, 0, 10, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
    ignore_out = 1'b0;
    chk("t4_ovf", 64'(ovf_err), 64'(1));
    pulse_clr();
    chk("t4_ovf_cleared", 64'(ovf_err), 64'(0));
    chk("t4_align_cleared", 64'(align_err), 64'(0));

    // Reversed order; swap_order flips mid-frame without effect.
    swap_order = 1'b1;
    run_frame(0, 0, 0, 8, 0, 0, 8, 8'hAA, 8'hBB, 8'hCC, 1'b1, 1'b1);
    chk("t5_first_data", 64'(first_data), 64'({PAD, 24'hCCBBAA}));
    chk("t5_swap_toggled", 64'(swap_order), 64'(0));
    run_frame(0, 0, 0, 8, 0, 0, 8, 8'hAA, 8'hBB, 8'hCC, 1'b1, 1'b0);
    chk("t5_next_first_data", 64'(first_data), 64'({PAD, 24'hAABBCC}));

    // Channel 1 sends one extra pixel.
    run_frame(0, 0, 0, 8, 0, 1, 8, 8'h70, 8'h80, 8'h90, 1'b1, 1'b0);
    chk("t6_align", 64'(align_err), 64'(1));
    chk("t6_fpc", 64'(frame_pix_cnt), 64'(8));
    pulse_clr();
    run_frame(0, 0, 0, 8, 0, 0, 8, 8'h05, 8'h06, 8'h07, 1'b1, 1'b0);
    chk("t6_next_align", 64'(align_err), 64'(0));
    chk("t6_next_fpc", 64'(frame_pix_cnt), 64'(8));
    chk("t6_next_href_count", 64'(href_cnt), 64'(8));

    // Reset in the middle of an active frame.
    ignore_out = 1'b1;
    @(negedge clk);
    ch_vsync = 3'b111;
    repeat (4) @(negedge clk);
    ch_href = 3'b111;
    ch_data = 24'h123456;
    repeat (3) @(negedge clk);
    chk("t7_pre_reset_vsync", 64'(post_img_vsync), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t7_rst_vsync", 64'(post_img_vsync), 64'(0));
    chk("t7_rst_href", 64'(post_img_href), 64'(0));
    chk("t7_rst_data", 64'(post_img_data), 64'(0));
    chk("t7_rst_fpc", 64'(frame_pix_cnt), 64'(0));
    ch_href = '0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    vs_cycles = 0;
    repeat (6) @(negedge clk);
    chk("t7_no_frame_without_rise", 64'(vs_cycles), 64'(0));
    ignore_out = 1'b0;
    idle(4);
    run_frame(0, 0, 0, 8, 0, 0, 8, 8'h21, 8'h31, 8'h41, 1'b1, 1'b0);
    chk("t7_after_reset_fpc", 64'(frame_pix_cnt), 64'(8));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
